rptr_empty_ctrl: RTL and testbench

//  Read-side pointer/flag controller for the dual-clock pointer FIFO. Lives in the read clock domain.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/gray2bin_conv.sv | 21 ++
 rtl/rptr_empty_ctrl.sv | 103 ++++++++++
 tb/tb_rptr_empty_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared defaults and Gray/binary helpers for both FIFO clock domains.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int c_ptr_width_def = 3;
    localparam int c_ae_thresh_def = 1;
    localparam int c_max_ptr_w     = 16;

    // Width-generic: callers zero-extend into c_max_ptr_w bits and cast the result back.
    function automatic logic [c_max_ptr_w-1:0] bin2gray(input logic [c_max_ptr_w-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [c_max_ptr_w-1:0] gray2bin(input logic [c_max_ptr_w-1:0] gray);
        logic [c_max_ptr_w-1:0] bin;
        bin[c_max_ptr_w-1] = gray[c_max_ptr_w-1];
        for (int i = c_max_ptr_w - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray2bin_conv.sv
// ============================================================================
// Module      : gray2bin_conv
// Description : Combinational Gray-to-binary converter (XOR prefix from the MSB).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray2bin_conv #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end

endmodule

`default_nettype wire

// File: rtl/rptr_empty_ctrl.sv
// ============================================================================
// Module      : rptr_empty_ctrl
// Description : Read-domain pointer and empty/almost-empty/level controller for
//               the dual-clock pointer FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rptr_empty_ctrl
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH = c_ptr_width_def,
    parameter int AE_THRESH = c_ae_thresh_def
) (
    input  logic               i_Rclk,
    input  logic               i_Rrst,
    input  logic               i_R_en,
    input  logic [PTR_WIDTH:0] i_g_wptr_sync,
    output logic [PTR_WIDTH:0] o_b_rptr,
    output logic [PTR_WIDTH:0] o_g_rptr,
    output logic               o_empty,
    output logic               o_almost_empty,
    output logic [PTR_WIDTH:0] o_rd_level,
    output logic               o_rd_valid,
    output logic               o_underflow
);

    localparam logic [PTR_WIDTH:0] c_ae_thresh = AE_THRESH[PTR_WIDTH:0];

    logic [PTR_WIDTH:0] r_b_rptr;
    logic [PTR_WIDTH:0] r_g_rptr;
    logic               r_empty;
    logic               r_almost_empty;
    logic [PTR_WIDTH:0] r_rd_level;
    logic               r_rd_valid;
    logic               r_underflow;

    logic               w_rd_acc;
    logic [PTR_WIDTH:0] w_b_next;
    logic [PTR_WIDTH:0] w_g_next;
    logic [PTR_WIDTH:0] w_wptr_bin;
    logic [PTR_WIDTH:0] w_level_next;
    logic               w_empty_next;
    logic               w_ae_next;

    gray2bin_conv #(
        .WIDTH (PTR_WIDTH + 1)
    ) u_wptr_g2b (
        .i_gray (i_g_wptr_sync),
        .o_bin  (w_wptr_bin)
    );

    // A read against a registered-empty FIFO is dropped; empty is pessimistic so this never loses data.
    assign w_rd_acc     = i_R_en & ~r_empty;
    assign w_b_next     = r_b_rptr + {{PTR_WIDTH{1'b0}}, w_rd_acc};
    assign w_g_next     = (PTR_WIDTH+1)'(bin2gray(c_max_ptr_w'(w_b_next)));
    assign w_empty_next = (w_g_next == i_g_wptr_sync);
    assign w_level_next = w_wptr_bin - w_b_next;
    assign w_ae_next    = (w_level_next <= c_ae_thresh);

    always_ff @(posedge i_Rclk or posedge i_Rrst) begin
        if (i_Rrst) begin
            r_b_rptr <= '0;
            r_g_rptr <= '0;
        end else begin
            r_b_rptr <= w_b_next;
            r_g_rptr <= w_g_next;
        end
    end

    always_ff @(posedge i_Rclk or posedge i_Rrst) begin
        if (i_Rrst) begin
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_rd_level     <= '0;
        end else begin
            r_empty        <= w_empty_next;
            r_almost_empty <= w_ae_next;
            r_rd_level     <= w_level_next;
        end
    end

    always_ff @(posedge i_Rclk or posedge i_Rrst) begin
        if (i_Rrst) begin
            r_rd_valid  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_valid  <= w_rd_acc;
            r_underflow <= r_underflow | (i_R_en & r_empty);
        end
    end

    assign o_b_rptr       = r_b_rptr;
    assign o_g_rptr       = r_g_rptr;
    assign o_empty        = r_empty;
    assign o_almost_empty = r_almost_empty;
    assign o_rd_level     = r_rd_level;
    assign o_rd_valid     = r_rd_valid;
    assign o_underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_rptr_empty_ctrl.sv
// ============================================================================
// Module      : tb_rptr_empty_ctrl
// Description : Directed and randomised self-checking bench for rptr_empty_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rptr_empty_ctrl;

    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic       r_en = 1'b0;
    logic [3:0] g_wptr_sync = 4'd0;

    logic [3:0] b_rptr;
    logic [3:0] g_rptr;
    logic       empty;
    logic       almost_empty;
    logic [3:0] rd_level;
    logic       rd_valid;
    logic       underflow;

    int compared   = 0;
    int mismatched = 0;

    rptr_empty_ctrl #(
        .PTR_WIDTH (3),
        .AE_THRESH (1)
    ) dut (
        .i_Rclk         (rclk),
        .i_Rrst         (rrst),
        .i_R_en         (r_en),
        .i_g_wptr_sync  (g_wptr_sync),
        .o_b_rptr       (b_rptr),
        .o_g_rptr       (g_rptr),
        .o_empty        (empty),
        .o_almost_empty (almost_empty),
        .o_rd_level     (rd_level),
        .o_rd_valid     (rd_valid),
        .o_underflow    (underflow)
    );

    always #5 rclk = ~rclk;

    function automatic logic [3:0] gray(input logic [3:0] b);
        return {b[3], b[3] ^ b[2], b[2] ^ b[1], b[1] ^ b[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eb, input logic ee,
                           input logic eae, input logic [3:0] el, input logic ev, input logic eu);
        chk({tag, ".b_rptr"}, 32'(b_rptr), 32'(eb));
        chk({tag, ".g_rptr"}, 32'(g_rptr), 32'(gray(eb)));
        chk({tag, ".empty"}, 32'(empty), 32'(ee));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(eae));
        chk({tag, ".rd_level"}, 32'(rd_level), 32'(el));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(ev));
        chk({tag, ".underflow"}, 32'(underflow), 32'(eu));
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    initial begin
        logic [3:0] w, m_b, nb, m_level, g_old;
        logic       m_empty, ren, acc;
        int         reads;
        int         cyc;

        // Reset held across clock edges
        tick(); tick();
        chk_all("reset", 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        rrst = 1'b0;
        tick();
        chk_all("post_reset", 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);

        // Underflow: reads while empty are dropped, sticky flag sets
        r_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("underflow", 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        end
        r_en = 1'b0;
        tick();
        chk("underflow_sticky", 32'(underflow), 32'd1);

        // Drain from level 5
        g_wptr_sync = 4'b0111;
        tick();
        chk_all("fill5", 4'd0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1);
        r_en = 1'b1;
        tick(); chk_all("drain1", 4'd1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1);
        tick(); chk_all("drain2", 4'd2, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1);
        tick(); chk_all("drain3", 4'd3, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1);
        tick(); chk_all("drain4", 4'd4, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1);
        tick(); chk_all("drain5", 4'd5, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
        chk("drain5_gray", 32'(g_rptr), 32'h7);
        r_en = 1'b0;
        tick(); chk_all("drain_idle", 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);

        // Full level (8) then advance the read pointer to 14
        g_wptr_sync = 4'b1011;
        tick(); chk_all("full8", 4'd5, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1);
        r_en = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk_all("drain8", 4'd13, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
        r_en = 1'b0;
        g_wptr_sync = 4'b1001;
        tick(); chk_all("lvl1", 4'd13, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
        r_en = 1'b1;
        tick(); chk_all("at14", 4'd14, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
        chk("at14_gray", 32'(g_rptr), 32'h9);

        // Wrap across the lap boundary
        r_en = 1'b0;
        g_wptr_sync = 4'b0011;
        tick(); chk_all("wrap_lvl4", 4'd14, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1);
        r_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk_all("wrap_done", 4'd2, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);

        // Simultaneous read and write-pointer update
        r_en = 1'b0;
        g_wptr_sync = 4'b0110;
        tick(); chk_all("sim_pre", 4'd2, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1);
        r_en = 1'b1;
        tick(); chk_all("sim_b3", 4'd3, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1);
        g_wptr_sync = 4'b0111;
        tick(); chk_all("sim_same_edge", 4'd4, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1);

        // Mid-run asynchronous reset with level 5
        r_en = 1'b0;
        g_wptr_sync = 4'b1101;
        tick(); chk_all("pre_rst_lvl5", 4'd4, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1);
        #2 rrst = 1'b1;
        #1 chk_all("async_rst", 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        g_wptr_sync = 4'd0;
        tick();
        rrst = 1'b0;
        tick();
        chk_all("after_rst", 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);

        // Random read / write-pointer traffic against a reference model
        w = 4'd0; m_b = 4'd0; m_empty = 1'b1; reads = 0; cyc = 0;
        while (reads < 32 * 16 && cyc < 20000) begin
            ren = 1'($urandom_range(0, 1));
            if (((w - m_b) < 4'd8) && ($urandom_range(0, 1) == 1)) w = w + 4'd1;
            r_en = ren;
            g_wptr_sync = gray(w);
            g_old = g_rptr;
            acc = ren & ~m_empty;
            nb = m_b + {3'd0, acc};
            m_empty = (nb == w);
            m_level = w - nb;
            m_b = nb;
            if (acc) reads++;
            tick();
            chk("rnd.b_rptr", 32'(b_rptr), 32'(m_b));
            chk("rnd.g_rptr", 32'(g_rptr), 32'(gray(m_b)));
            chk("rnd.gray_step", 32'($countones(g_rptr ^ g_old)), 32'(acc));
            chk("rnd.empty", 32'(empty), 32'(m_empty));
            chk("rnd.level", 32'(rd_level), 32'(m_level));
            chk("rnd.inv_empty", 32'(empty), 32'(rd_level == 4'd0));
            chk("rnd.inv_max", 32'(rd_level <= 4'd8), 32'd1);
            chk("rnd.valid", 32'(rd_valid), 32'(acc));
            cyc++;
        end
        chk("rnd.laps_done", 32'(reads >= 32 * 16), 32'd1);
        r_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
